// File: rtl/clock_digit_scan.sv
// clock_digit_scan: splits hour/min/sec into six decimal digits and scans them onto a shared digit bus.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-low reset
//   hour  - binary hours 0..23 (larger values clamp to 23)
//   min   - binary minutes 0..59 (larger values clamp to 59)
//   sec   - binary seconds 0..59 (larger values clamp to 59)
//   num   - current digit 0..9 for the 7-segment decoder
//   com_n - active-low one-hot digit enables, bit0 = hour tens .. bit5 = sec ones
// Optional: define CLOCK_HOUR_BLANK_EN to darken the hour-tens digit when hours < 10.
module clock_digit_scan #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] hour,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  output logic [5:0] num,
  output logic [5:0] com_n
);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d, idx_p_q;
  logic [5:0]    hour_q, hour_d, min_q, min_d, sec_q, sec_d;
  logic [5:0]    num_q, num_d, com_n_q, com_n_d, sel_v;
  logic          vld_q, slot_end, cap;
  function automatic logic [3:0] tens_of(input logic [5:0] v);
    return v >= 6'd50 ? 4'd5 :
           v >= 6'd40 ? 4'd4 :
           v >= 6'd30 ? 4'd3 :
           v >= 6'd20 ? 4'd2 :
           v >= 6'd10 ? 4'd1 : 4'd0;
  endfunction
  function automatic logic [3:0] ones_of(input logic [5:0] v);
    logic [5:0] t;
    t = {2'b00, tens_of(v)};
    return 4'(v - (t << 3) - (t << 1));
  endfunction
  always_comb begin
    slot_end = cnt_q == CW'(SCAN_DIV - 1);
    cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
    idx_d    = !slot_end ? idx_q : (idx_q == 3'd5 ? 3'd0 : idx_q + 3'd1);
    // shadow copies change only at the frame boundary so a frame never mixes two times
    cap      = slot_end && idx_q == 3'd5;
    hour_d   = !cap ? hour_q : (hour > 6'd23 ? 6'd23 : hour);
    min_d    = !cap ? min_q : (min > 6'd59 ? 6'd59 : min);
    sec_d    = !cap ? sec_q : (sec > 6'd59 ? 6'd59 : sec);
    sel_v    = idx_q < 3'd2 ? hour_q : idx_q < 3'd4 ? min_q : sec_q;
    num_d    = {2'b00, idx_q[0] ? ones_of(sel_v) : tens_of(sel_v)};
    // vld_q keeps the enables dark until the delayed index holds a real slot
    com_n_d  = vld_q ? ~(6'b1 << idx_p_q) : 6'h3f;
`ifdef CLOCK_HOUR_BLANK_EN
    if (idx_p_q == 3'd0 && hour_q < 6'd10) com_n_d = 6'h3f;
`endif
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      idx_p_q <= '0;
      hour_q  <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      num_q   <= '0;
      com_n_q <= 6'h3f;
      vld_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      idx_p_q <= idx_q;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      num_q   <= num_d;
      com_n_q <= com_n_d;
      vld_q   <= 1'b1;
    end
  end
  assign num   = num_q;
  assign com_n = com_n_q;
endmodule

// File: tb/tb_clock_digit_scan.sv
// tb_clock_digit_scan: directed stimulus with a cycle-count based reference model for clock_digit_scan.
module tb_clock_digit_scan;
  localparam int SD = 4;
  localparam int FR = 6 * SD;
`ifdef CLOCK_HOUR_BLANK_EN
  localparam logic [5:0] C0 = 6'h3f;
`else
  localparam logic [5:0] C0 = 6'h3e;
`endif
  logic clk, reset;
  logic [5:0] hour, min, sec, num, com_n;
  int n = 0;
  int tests = 0;
  int fails = 0;
  logic [5:0] cap_h[64], cap_m[64], cap_s[64];

  clock_digit_scan #(.SCAN_DIV(SD)) dut (
    .clk(clk), .reset(reset), .hour(hour), .min(min), .sec(sec), .num(num), .com_n(com_n)
  );

  always #5 clk = ~clk;

  // n counts rising edges since reset release; frame k shows the inputs seen at edge k*FR
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      n <= 0;
      cap_h[0] <= 6'd0;
      cap_m[0] <= 6'd0;
      cap_s[0] <= 6'd0;
    end else begin
      n <= n + 1;
      if ((n + 1) % FR == 0 && (n + 1) / FR < 64) begin
        cap_h[(n + 1) / FR] <= hour > 23 ? 6'd23 : hour;
        cap_m[(n + 1) / FR] <= min > 59 ? 6'd59 : min;
        cap_s[(n + 1) / FR] <= sec > 59 ? 6'd59 : sec;
      end
    end
  end

  function automatic logic [5:0] digit_of(input int f, input int s);
    int v;
    v = s < 2 ? int'(cap_h[f]) : s < 4 ? int'(cap_m[f]) : int'(cap_s[f]);
    return 6'(s % 2 == 0 ? v / 10 : v % 10);
  endfunction

  function automatic logic [5:0] exp_num(input int k);
    return k == 0 ? 6'd0 : digit_of((k - 1) / FR, ((k - 1) / SD) % 6);
  endfunction

  function automatic logic [5:0] exp_com(input int k);
    int s;
    int f;
    if (k < 2) return 6'h3f;
    s = ((k - 2) / SD) % 6;
    f = (k - 2) / FR;
`ifdef CLOCK_HOUR_BLANK_EN
    if (s == 0 && cap_h[f] < 10) return 6'h3f;
`endif
    return ~(6'b1 << s);
  endfunction

  task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s n=%0d: got %b expected %b", nm, n, act, exp);
    end
  endtask

  task automatic at_n(input int k);
    int t;
    t = 0;
    while (n != k && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (n != k) begin
      fails++;
      tests++;
      $display("FAIL timeout waiting for n=%0d: got n=%0d", k, n);
    end
  endtask

  always @(negedge clk) begin
    chk("num", num, exp_num(n));
    chk("com_n", com_n, exp_com(n));
  end

  initial begin
    clk = 0; reset = 1; hour = 0; min = 0; sec = 0;
    #2 reset = 0;
    repeat (3) @(negedge clk);
    reset = 1;
    at_n(1);  chk("lit_num_first", num, 6'd0); chk("lit_com_first", com_n, 6'h3f);
    at_n(2);  chk("lit_com_slot0", com_n, C0);
    hour = 12; min = 34; sec = 56;
    at_n(25); chk("lit_htens", num, 6'd1);
    at_n(26); chk("lit_com0", com_n, 6'b111110);
    at_n(29); chk("lit_hones", num, 6'd2);
    at_n(45); chk("lit_sones", num, 6'd6);
    at_n(46); chk("lit_com5", com_n, 6'b011111);
    at_n(57); sec = 7;
    at_n(65); chk("lit_old_stens", num, 6'd5);
    at_n(69); chk("lit_old_sones", num, 6'd6);
    at_n(89); chk("lit_new_stens", num, 6'd0);
    at_n(93); chk("lit_new_sones", num, 6'd7);
    at_n(97); hour = 31; min = 60; sec = 63;
    at_n(121); chk("lit_clamp_h", num, 6'd2);
    at_n(133); chk("lit_clamp_m", num, 6'd9);
    at_n(158);
    reset = 0; hour = 7; min = 0; sec = 0;
    #1 chk("lit_rst_num", num, 6'd0); chk("lit_rst_com", com_n, 6'h3f);
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    at_n(25); chk("lit_h7_tens", num, 6'd0);
    at_n(26); chk("lit_h7_com0", com_n, C0);
    at_n(29); chk("lit_h7_ones", num, 6'd7);
    at_n(30); chk("lit_h7_com1", com_n, 6'b111101);
    at_n(50);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/clock_digit_scan.md
Name: clock_digit_scan

Overview:
- Upstream neighbour of the 7-segment decoder in the digital clock display path.
- Takes binary hour/minute/second values and splits each into tens and ones digits.
- Time-multiplexes the six digits onto one shared digit bus (num) that feeds the decoder.
- Drives active-low digit-common enables (com_n), delayed to line up with the decoder's one-cycle registered segment output.

Parameters:
SCAN_DIV, 50000, clk cycles each digit stays lit (min 2); cnt width = $clog2(SCAN_DIV)

Ports:
clk     input   1  system clock, all logic on rising edge
reset   input   1  asynchronous active-low reset (reset==0 clears all state)
hour    input   6  binary hours, legal 0..23
min     input   6  binary minutes, legal 0..59
sec     input   6  binary seconds, legal 0..59
num     output  6  digit value 0..9 for the decoder; bits [5:4] always 0
com_n   output  6  digit enables, active-low, one-hot-low; com_n[0]=hour tens (leftmost) .. com_n[5]=sec ones

Behaviour:
- Reset: applies immediately on reset==0, independent of clk. Clears cnt=0, idx=0, shadow hour/min/sec=0, idx_d=0, num=6'd0, com_n=6'b111111 (all off). Reset mid-scan aborts the frame; the first frame after release shows 00:00:00.
- Prescaler cnt: 0..SCAN_DIV-1, +1 every clk; at SCAN_DIV-1 wraps to 0 and raises slot_end for that cycle.
- Slot index idx: 0..5; on slot_end, idx+1, wrapping 5->0.
- Digit order: idx0 hour tens, idx1 hour ones, idx2 min tens, idx3 min ones, idx4 sec tens, idx5 sec ones.
- Frame snapshot: on slot_end with idx==5, capture hour/min/sec into shadow regs. Input changes at any other time are invisible until the next frame boundary (no tearing).
- Clamp at capture: hour>23 stored as 23; min>59 or sec>59 stored as 59.
- Digit split: tens = v/10 via a compare chain (>=50:5, >=40:4, ...), ones = v - 10*tens. No divider operator.
- Pipeline alignment:
  - num <= digit(idx, shadow) every clk, so num lags idx by 1 cycle.
  - idx_d <= idx; com_n <= ~(6'b1 << idx_d), so com_n lags idx by 2 cycles. This matches decoder seg, which lags num by 1.
- Exactly one com_n bit is low at any time after the first two post-reset cycles. During those two cycles com_n=111111.
- num is never outside 0..9.

Optional Feature:
Macro CLOCK_HOUR_BLANK_EN
- Defined: when shadow hour<10, the hour-tens slot (idx0) keeps com_n[0]=1 for the whole slot, so the digit is dark. num still carries 0. The alignment delay is unchanged.
- Undefined: the hour-tens digit always displays, including a leading 0.

Test Plan (SCAN_DIV=4 unless noted):
1. Reset held, then released with inputs 0 -> com_n=111111 and num=0 through 2 cycles; then com_n=111110, each bit low for 4 cycles in turn, num=0 throughout.
2. hour=12, min=34, sec=56 applied before the first frame wrap -> following frame num sequence 1,2,3,4,5,6, each held 4 cycles; com_n walks 111110,111101,111011,110111,101111,011111 with 1 cycle lag behind num.
3. Change sec 56->07 while idx==2 -> current frame still shows 5,6 in slots 4-5; next frame shows 0,7.
4. hour=31, min=60, sec=63 -> displayed digits 2,3,5,9,5,9.
5. Assert reset during idx==3, cnt==2 -> next edge com_n=111111, num=0; after release the scan restarts at idx0.
6. CLOCK_HOUR_BLANK_EN defined, hour=7 -> com_n[0] stays 1 during slot 0 while num=0; slot 1 shows num=7 with com_n=111101. Without the macro, slot 0 drives com_n=111110.
